// File: rtl/rom_arb_pkg.sv
// Shared types and the round-robin winner function for the ROM read-channel arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {RESYNC, IDLE, WAIT} arb_state_t;

  localparam int MAX_REQ = 8;

  // Scan upward from ptr (wrapping at n) and return the first pending index.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] pend,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0] win;
    logic [2:0] idx;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = 3'((32'(ptr) + k) % n);
      if (!found && (k < n) && pend[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_select.sv
// Combinational winner selection: round-robin from ptr, optionally overridden by port 0.
module rr_select
  import rom_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PRIO0 = 0,
  localparam int GW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [GW-1:0]    ptr,
  output logic [GW-1:0]    winner
);

  always_comb begin
    winner = GW'(rr_pick(MAX_REQ'(pend), 3'(ptr), N_REQ));
    if ((PRIO0 != 0) && pend[0]) begin
      winner = '0;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one toggle-handshake ROM read channel among N_REQ toggle-handshake requesters.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 27,
  parameter int DATA_W = 16,
  parameter int PRIO0  = 0,
  localparam int GW    = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ*ADDR_W-1:0]  req_address,
  input  logic [N_REQ-1:0]         req_req,
  output logic [N_REQ-1:0]         req_ack,
  output logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [ADDR_W-1:0]        rom_address,
  output logic                     rom_req,
  input  logic                     rom_ack,
  input  logic [DATA_W-1:0]        rom_data,
  output logic                     busy,
  output logic [GW-1:0]            grant
);

  arb_state_t        state, state_nxt;
  logic [N_REQ-1:0]  pend;
  logic [GW-1:0]     rr_ptr;
  logic [GW-1:0]     winner;
  logic [GW-1:0]     grant_inc;
  logic              rom_match;
  logic              do_grant;
  logic              do_done;

  assign pend      = req_req ^ req_ack;
  assign rom_match = (rom_ack == rom_req);
  assign busy      = (state != IDLE);
  assign grant_inc = (grant == GW'(N_REQ - 1)) ? '0 : grant + 1'b1;

  rr_select #(
    .N_REQ (N_REQ),
    .PRIO0 (PRIO0)
  ) u_rr_select (
    .pend   (pend),
    .ptr    (rr_ptr),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RESYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    case (state)
      RESYNC: state_nxt = IDLE;
      IDLE: begin
        if (pend != '0) begin
          do_grant  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (rom_match) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = RESYNC;
    endcase
  end

  // RESYNC realigns rom_req so a transaction orphaned by reset is never left outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ack     <= '0;
      req_data    <= '0;
      rom_address <= '0;
      rom_req     <= 1'b0;
      grant       <= '0;
      rr_ptr      <= '0;
    end else begin
      if (state == RESYNC) begin
        rom_req <= rom_ack;
      end
      if (do_grant) begin
        rom_address <= req_address[winner*ADDR_W +: ADDR_W];
        rom_req     <= ~rom_req;
        grant       <= winner;
      end
      if (do_done) begin
        req_data[grant*DATA_W +: DATA_W] <= rom_data;
        req_ack[grant]                   <= ~req_ack[grant];
        rr_ptr                           <= grant_inc;
      end
    end
  end

endmodule
